led_sequencer: RTL and testbench

Parametrised LED pattern generator; successor to the fixed 8-bit single-mode chaser. Drives a WIDTH-bit LED bank with one of four runtime-selectable patterns, advancing at a runtime-programmable clock divide. Also supports pause and manual single-step. Sits between the board control registers/switches and the LED pins; one instance per LED bank.

---
 rtl/led_sequencer.sv | 162 ++++++++++++++++
 tb/tb_led_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// WIDTH-bit LED pattern generator: rotate-left, rotate-right, bounce and fill/drain
// patterns, advancing at a programmable clock divide, with pause and single-step.
module led_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 step,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [WIDTH-1:0]     led,
    output logic                 tick
);

    localparam logic [WIDTH-1:0]     LED_ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     LED_ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]     LED_LSB     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     LED_MSB     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO    = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE     = DIV_WIDTH'(1);
    localparam logic                 DIR_UP      = 1'b0;
    localparam logic                 DIR_DOWN    = 1'b1;
    localparam logic                 PHASE_FILL  = 1'b0;
    localparam logic                 PHASE_DRAIN = 1'b1;

    function automatic logic [WIDTH-1:0] mode_seed(input logic [1:0] m);
        logic [WIDTH-1:0] s;
        case (m)
            2'd0, 2'd2: s = LED_LSB;
            2'd1:       s = LED_MSB;
            default:    s = LED_ZERO;
        endcase
        return s;
    endfunction

    logic [WIDTH-1:0]     led_r,     led_s;
    logic                 tick_r,    tick_s;
    logic [DIV_WIDTH-1:0] div_cnt_r, div_cnt_s;
    logic [1:0]           mode_r,    mode_s;
    logic                 dir_r,     dir_s;
    logic                 phase_r,   phase_s;
    logic [DIV_WIDTH-1:0] eff_last_s;
    logic                 advance_s;

    // Advance qualifier; >= lets a runtime decrease of div fire immediately.
    always_comb begin
        eff_last_s = (div == DIV_ZERO) ? DIV_ZERO : (div - DIV_ONE);
        if (en) begin
            advance_s = (div_cnt_r >= eff_last_s);
        end else begin
            advance_s = step;
        end
    end

    // Next-state logic: a mode change reloads and suppresses any advance.
    always_comb begin
        led_s     = led_r;
        tick_s    = 1'b0;
        div_cnt_s = div_cnt_r;
        mode_s    = mode_r;
        dir_s     = dir_r;
        phase_s   = phase_r;
        if (mode != mode_r) begin
            mode_s    = mode;
            div_cnt_s = DIV_ZERO;
            led_s     = mode_seed(mode);
            dir_s     = DIR_UP;
            phase_s   = PHASE_FILL;
        end else if (advance_s) begin
            tick_s = 1'b1;
            if (en) begin
                div_cnt_s = DIV_ZERO;
            end else begin
                div_cnt_s = div_cnt_r;
            end
            case (mode_r)
                2'd0: begin
                    if (led_r == LED_ZERO) begin
                        led_s = LED_LSB;
                    end else begin
                        led_s = {led_r[WIDTH-2:0], led_r[WIDTH-1]};
                    end
                end
                2'd1: begin
                    if (led_r == LED_ZERO) begin
                        led_s = LED_MSB;
                    end else begin
                        led_s = {led_r[0], led_r[WIDTH-1:1]};
                    end
                end
                2'd2: begin
                    if (led_r == LED_ZERO) begin
                        led_s = LED_LSB;
                        dir_s = DIR_UP;
                    end else if (dir_r == DIR_UP) begin
                        if (led_r[WIDTH-1]) begin
                            dir_s = DIR_DOWN;
                            led_s = led_r >> 1;
                        end else begin
                            led_s = led_r << 1;
                        end
                    end else begin
                        if (led_r[0]) begin
                            dir_s = DIR_UP;
                            led_s = led_r << 1;
                        end else begin
                            led_s = led_r >> 1;
                        end
                    end
                end
                default: begin
                    if (phase_r == PHASE_FILL) begin
                        led_s = {led_r[WIDTH-2:0], 1'b1};
                        if (led_s == LED_ONES) begin
                            phase_s = PHASE_DRAIN;
                        end else begin
                            phase_s = PHASE_FILL;
                        end
                    end else begin
                        led_s = {led_r[WIDTH-2:0], 1'b0};
                        if (led_s == LED_ZERO) begin
                            phase_s = PHASE_FILL;
                        end else begin
                            phase_s = PHASE_DRAIN;
                        end
                    end
                end
            endcase
        end else begin
            if (en) begin
                div_cnt_s = div_cnt_r + DIV_ONE;
            end else begin
                div_cnt_s = div_cnt_r;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r     <= LED_LSB;
            tick_r    <= 1'b0;
            div_cnt_r <= DIV_ZERO;
            mode_r    <= 2'd0;
            dir_r     <= DIR_UP;
            phase_r   <= PHASE_FILL;
        end else begin
            led_r     <= led_s;
            tick_r    <= tick_s;
            div_cnt_r <= div_cnt_s;
            mode_r    <= mode_s;
            dir_r     <= dir_s;
            phase_r   <= phase_s;
        end
    end

    assign led  = led_r;
    assign tick = tick_r;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: an index-based pattern model pushes the
// expected led/tick into a queue each cycle; the value is popped after the edge.
module tb_led_sequencer;

    localparam int W  = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          step;
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic [W-1:0]  led;
    logic          tick;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];
    int         m_mode;
    int         m_idx;
    longint     m_cnt;
    logic       m_tick;

    always #5 clk = ~clk;

    led_sequencer #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .step  (step),
        .mode  (mode),
        .div   (div),
        .led   (led),
        .tick  (tick)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pattern value as a function of the number of advances since the seed.
    function automatic logic [W-1:0] model_led(input int md, input int idx);
        logic [W-1:0] ones;
        logic [W-1:0] one;
        logic [W-1:0] r;
        int k;
        ones = '1;
        one  = 1;
        case (md)
            0: r = one << (idx % W);
            1: r = one << (W - 1 - (idx % W));
            2: begin
                k = idx % (2 * W - 2);
                if (k < W) r = one << k;
                else r = one << (2 * W - 2 - k);
            end
            default: begin
                k = idx % (2 * W);
                if (k <= W) r = ~(ones << k);
                else r = ones << (k - W);
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_idx  = 0;
        m_cnt  = 0;
        m_tick = 1'b0;
    endtask

    task automatic cycle(input string tag);
        logic [W:0] e;
        longint effd;
        if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_idx  = 0;
            m_cnt  = 0;
            m_tick = 1'b0;
        end else begin
            effd   = (div == 0) ? 64'd1 : longint'(div);
            m_tick = 1'b0;
            if (en) begin
                if (m_cnt + 1 >= effd) begin
                    m_idx++;
                    m_cnt  = 0;
                    m_tick = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else if (step) begin
                m_idx++;
                m_tick = 1'b1;
            end
        end
        exp_q.push_back({m_tick, model_led(m_mode, m_idx)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({tag, ".led"}, 32'(led), 32'(e[W-1:0]));
        check_val({tag, ".tick"}, 32'(tick), 32'(e[W]));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        step  = 1'b0;
        mode  = 2'd0;
        div   = 4;
        model_reset();
        #12;
        check_val("reset.led", 32'(led), 32'h01);
        check_val("reset.tick", 32'(tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        repeat (40) cycle("rotl_div4");

        mode = 2'd2;
        div  = 1;
        repeat (30) cycle("bounce");

        mode = 2'd3;
        repeat (36) cycle("filldrain");

        mode = 2'd0;
        en   = 1'b0;
        div  = 4;
        cycle("pause_reload");
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            cycle("step");
            step = 1'b0;
            repeat (4) cycle("step_gap");
        end
        check_val("three_steps", 32'(led), 32'h08);
        repeat (20) cycle("static");
        step = 1'b1;
        repeat (3) cycle("step_hold");
        step = 1'b0;

        en  = 1'b1;
        div = 10;
        repeat (7) cycle("div10");
        div = 2;
        cycle("div_dec");
        check_val("div_dec_tick", 32'(tick), 32'h1);
        repeat (8) cycle("div2");
        div = 0;
        repeat (8) cycle("div0");

        div  = 4;
        mode = 2'd3;
        cycle("pre_switch_a");
        mode = 2'd0;
        cycle("pre_switch_b");
        repeat (3) cycle("pre_switch_run");
        mode = 2'd1;
        cycle("switch");
        check_val("switch_led", 32'(led), 32'h80);
        check_val("switch_tick", 32'(tick), 32'h0);
        repeat (4) cycle("after_switch");
        check_val("after_switch_led", 32'(led), 32'h40);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            en   = ($urandom_range(0, 3) != 0);
            step = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       div = 0;
                1:       div = 1;
                2:       div = 2;
                3:       div = 3;
                default: div = 5;
            endcase
            cycle("random");
        end

        #3;
        rst_n = 1'b0;
        #1;
        check_val("midreset.led", 32'(led), 32'h01);
        check_val("midreset.tick", 32'(tick), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check_val("midreset_hold.led", 32'(led), 32'h01);
        mode = 2'd2;
        en   = 1'b1;
        step = 1'b0;
        div  = 3;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) cycle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
